// File: rtl/memacc_pkg.sv
// Shared encodings for the memory access unit: access sizes and dump FSM states.
package memacc_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/memacc_ram.sv
// Byte-enable data memory with one synchronous read/write port (old data on read-during-write).
module memacc_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic [DATA_W/8-1:0]        we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_access_unit.sv
// MEM stage: aligned byte/half/word loads and stores, branch resolve, optional memory dump.
// Define MEMACC_DEBUG_DUMP_EN to build the dump FSM behind the out_du_* / out_stall ports.
module memory_access_unit import memacc_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         in_addr,
    input  logic                      in_zero,
    input  logic                      in_branch,
    input  logic                      in_mem_rd,
    input  logic                      in_mem_wr,
    input  logic [1:0]                in_size,
    input  logic                      in_unsigned,
    input  logic [DATA_W-1:0]         in_wrd,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      out_PCSrc,
    output logic                      out_misalign,
    input  logic                      in_du_dump,
    output logic [DATA_W-1:0]         out_du_data,
    output logic [$clog2(DEPTH)-1:0]  out_du_addr,
    output logic                      out_du_valid,
    output logic                      out_du_done,
    output logic                      out_stall
);

    localparam int LANES = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH);

    logic [AW-1:0]     idx, ram_addr;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata, rdata, ext;
    logic              mis, access_ok, wr_go, rd_go, stall;
    logic              ld_valid, ld_mis, ld_uns;
    logic [1:0]        ld_off, ld_size;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              unused_addr;

    assign out_PCSrc   = in_zero & in_branch;
    assign idx         = in_addr[AW+1:2];
    assign unused_addr = ^in_addr[DATA_W-1:AW+2];
    assign access_ok   = !stall && !reset;

    always_comb begin
        case (in_size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = in_addr[0];
            default: mis = (in_addr[1:0] != 2'b00);
        endcase
    end

    assign wr_go = access_ok && in_mem_wr && !mis;
    assign rd_go = access_ok && in_mem_rd && !in_mem_wr;

    // Right-aligned store data is moved up to the addressed lanes
    always_comb begin
        be    = '1;
        wdata = in_wrd;
        case (in_size)
            SZ_BYTE: begin
                be    = LANES'(1) << in_addr[1:0];
                wdata = in_wrd << {in_addr[1:0], 3'b000};
            end
            SZ_HALF: begin
                be    = LANES'(3) << {in_addr[1], 1'b0};
                wdata = in_wrd << {in_addr[1], 4'b0000};
            end
            default: ;
        endcase
        if (!wr_go) be = '0;
    end

    memacc_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (be),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_valid     <= 1'b0;
            ld_mis       <= 1'b0;
            ld_off       <= '0;
            ld_size      <= '0;
            ld_uns       <= 1'b0;
            out_misalign <= 1'b0;
        end else begin
            ld_valid     <= rd_go;
            ld_mis       <= mis;
            ld_off       <= in_addr[1:0];
            ld_size      <= in_size;
            ld_uns       <= in_unsigned;
            out_misalign <= access_ok && (in_mem_rd || in_mem_wr) && mis;
        end
    end

    // Load side: the RAM output register plus the captured request form the 1-cycle result
    assign ld_byte = rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = rdata[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        case (ld_size)
            SZ_BYTE: ext = ld_uns ? {{(DATA_W-8){1'b0}}, ld_byte}
                                  : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            SZ_HALF: ext = ld_uns ? {{(DATA_W-16){1'b0}}, ld_half}
                                  : {{(DATA_W-16){ld_half[15]}}, ld_half};
            default: ext = rdata;
        endcase
    end

    assign out_valid = ld_valid;
    assign out_data  = (ld_valid && !ld_mis) ? ext : '0;
    assign out_stall = stall;

`ifdef MEMACC_DEBUG_DUMP_EN
    dump_state_t       state, state_nxt;
    logic [AW-1:0]     cnt;
    logic              du_valid_q;
    logic [AW-1:0]     du_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            du_valid_q <= 1'b0;
            du_addr_q  <= '0;
        end else begin
            state      <= state_nxt;
            du_valid_q <= (state == ST_DUMP);
            du_addr_q  <= cnt;
            cnt        <= (state == ST_DUMP) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_du_dump) state_nxt = ST_DUMP;
            ST_DUMP: if (cnt == AW'(DEPTH-1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stall        = (state != ST_IDLE);
    assign ram_addr     = (state == ST_DUMP) ? cnt : idx;
    assign out_du_valid = du_valid_q;
    assign out_du_addr  = du_addr_q;
    assign out_du_data  = du_valid_q ? rdata : '0;
    assign out_du_done  = (state == ST_DONE);
`else
    logic unused_dump;

    assign unused_dump  = in_du_dump;
    assign stall        = 1'b0;
    assign ram_addr     = idx;
    assign out_du_valid = 1'b0;
    assign out_du_addr  = '0;
    assign out_du_data  = '0;
    assign out_du_done  = 1'b0;
`endif

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, 32, data/address width in bits (multiple of 8, at least 32).
REQ-002 SHALL have parameter DEPTH, 256, data-memory depth in words (power of two).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_addr, input, DATA_W, byte address from EX/MEM ALU.
REQ-006 SHALL have ports in_zero, in_branch, in_mem_rd, in_mem_wr, input, 1 each, the ALU zero flag and MEM control flags.
REQ-007 SHALL have port in_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 SHALL have port in_unsigned, input, 1, zero-extends loads when 1 and sign-extends them when 0.
REQ-009 SHALL have port in_wrd, input, DATA_W, store data, right-aligned.
REQ-010 SHALL have ports out_data, output, DATA_W, the load result, and out_valid, output, 1, which qualifies it.
REQ-011 SHALL have ports out_PCSrc, output, 1, and out_misalign, output, 1, the misalignment pulse.
REQ-012 SHALL have debug ports in_du_dump, input, 1, dump request; out_du_data, output, DATA_W, dumped word; out_du_addr, output, clog2(DEPTH), dumped word index; out_du_valid, output, 1, which qualifies the dumped word; out_du_done, output, 1, end-of-dump pulse; out_stall, output, 1, pipeline stall.

Function
REQ-013 out_PCSrc SHALL equal in_zero AND in_branch, combinationally.
REQ-014 Word index SHALL be in_addr[clog2(DEPTH)+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo DEPTH.
REQ-015 Stores SHALL write only the addressed lanes: a byte store writes lane in_addr[1:0]; a half store writes lanes at in_addr[1]*2; a word store writes all lanes.
REQ-016 Loads SHALL have 1-cycle latency: out_data and out_valid are registered, and out_valid is high exactly in the cycle after an accepted read.
REQ-017 Loaded bytes and halves SHALL be shifted down to bit 0 and extended per in_unsigned.
REQ-018 An access is misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]≠00; a misaligned access SHALL suppress the write, return out_data=0 with out_valid=1 for a read, and pulse out_misalign for one cycle (registered).
REQ-019 When in_mem_rd and in_mem_wr are both high, the write SHALL be performed and the read ignored (out_valid=0).
REQ-020 The dump FSM SHALL have states IDLE, DUMP and DONE.
REQ-021 IDLE→DUMP SHALL occur on in_du_dump=1; any pipeline access in that same cycle completes normally.
REQ-022 In DUMP, out_stall=1, pipeline reads and writes SHALL be suppressed, and one word SHALL be read per cycle at an index counting 0..DEPTH-1.
REQ-023 The dumped word SHALL appear with out_du_valid=1 and out_du_addr one cycle after its read.
REQ-024 After index DEPTH-1 is read, the FSM SHALL go DUMP→DONE; DONE SHALL drive the final out_du_valid and pulse out_du_done, then return to IDLE.
REQ-025 in_du_dump SHALL be ignored outside IDLE.
REQ-026 out_stall SHALL be 1 in DUMP and DONE and 0 otherwise.

Reset
REQ-027 Reset SHALL set the FSM to IDLE, the counter to 0, and drive out_data, out_valid, out_misalign, out_du_* and out_stall to 0; reset during a dump SHALL abort it without asserting out_du_done.
REQ-028 Reset SHALL NOT clear memory contents.

Configuration
REQ-029 With MEMACC_DEBUG_DUMP_EN defined, the dump FSM and debug ports SHALL be functional.
REQ-030 Without MEMACC_DEBUG_DUMP_EN, the ports SHALL remain present, in_du_dump SHALL be ignored, all out_du_* outputs and out_stall SHALL be constant 0, and no FSM logic SHALL be generated.

Structure
REQ-031 Package memacc_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-032 Sub-module memacc_ram SHALL implement the byte-enable synchronous-read RAM, with one read/write port plus the dump read mux in the parent.

Verification
REQ-033 SW 0xDEADBEEF @0x10, then LW @0x10 -> out_data=0xDEADBEEF, with out_valid high one cycle after the read.
REQ-034 SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; the other lanes of word 8 are unchanged.
REQ-035 SH @0x13 -> no write and out_misalign pulses once; LW @0x12 -> out_data=0, out_misalign=1.
REQ-036 in_zero=1, in_branch=1 -> out_PCSrc=1 in the same cycle; either input at 0 -> out_PCSrc=0.
REQ-037 With DEPTH=16 and dump enabled, pulse in_du_dump -> 16 consecutive out_du_valid beats (addr 0..15), then out_du_done, with out_stall high throughout and in_mem_wr ignored.
REQ-038 Assert reset at dump beat 5 -> next cycle FSM is IDLE, out_stall=0, no out_du_done; a subsequent dump restarts at addr 0.
